// File: rtl/mul_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_pkg
// Description : Shared types and constants for the multiplier-sharing block.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_share_pkg;

    localparam int NUM_REQ   = 2;
    localparam int DATA_W    = 32;
    localparam int MUL_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Tags wider than MUL_TAG_W are truncated when stored.
    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic                 sign;
        logic [MUL_TAG_W-1:0] tag;
    } mul_req_t;

endpackage
`default_nettype wire

// File: rtl/mul_share_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; pointer moves past each winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mul_share_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               en,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic               owner
);

    logic r_rr_ptr;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        owner = r_rr_ptr;
        if (valid == 2'b01) begin
            owner = 1'b0;
        end else if (valid == 2'b10) begin
            owner = 1'b1;
        end
        grant = 2'b00;
        if (en && (|valid)) begin
            grant = owner ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (advance) begin
            r_rr_ptr <= ~owner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_ctrl
// Description : Shares one single-cycle multiplier between two issue slots.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_sign,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_sign,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic [63:0]      resp0_result,
    output logic [TAG_W-1:0] resp0_tag,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    output logic [63:0]      resp1_result,
    output logic [TAG_W-1:0] resp1_tag,
    input  logic             resp1_ready,
    input  logic             flush,
    output logic             mul_start,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic             mul_sign,
    input  logic             mul_ready,
    input  logic [63:0]      mul_result
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]         r_state;
    mul_req_t           r_req;
    logic               r_owner;
    logic               r_drop;
    logic [63:0]        r_result;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_owner;
    logic               w_en;
    logic               w_accept;
    logic               w_resp0_valid;
    logic               w_resp1_valid;
    logic               w_resp_fire;
    mul_req_t           w_sel;

    assign w_en     = (r_state == S_IDLE) && !flush;
    assign w_accept = |w_grant;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .en      (w_en),
        .advance (w_accept),
        .grant   (w_grant),
        .owner   (w_owner)
    );

    always_comb begin
        if (w_owner) begin
            w_sel = '{a: req1_a, b: req1_b, sign: req1_sign, tag: MUL_TAG_W'(req1_tag)};
        end else begin
            w_sel = '{a: req0_a, b: req0_b, sign: req0_sign, tag: MUL_TAG_W'(req0_tag)};
        end
    end

    assign w_resp0_valid = (r_state == S_RESP) && !r_owner;
    assign w_resp1_valid = (r_state == S_RESP) &&  r_owner;
    assign w_resp_fire   = (w_resp0_valid && resp0_ready) || (w_resp1_valid && resp1_ready);

    // r_drop marks an operation already started on the multiplier whose
    // result must be swallowed so its done pulse cannot leak into the next op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_req    <= '0;
            r_owner  <= 1'b0;
            r_drop   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req   <= w_sel;
                        r_owner <= w_owner;
                        r_drop  <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_ready) begin
                        if (r_drop || flush) begin
                            r_drop  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_result <= mul_result;
                            r_state  <= S_RESP;
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_resp_fire || flush) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready   = w_grant[0];
    assign req1_ready   = w_grant[1];

    assign mul_start    = (r_state == S_ISSUE);
    assign mul_a        = r_req.a;
    assign mul_b        = r_req.b;
    assign mul_sign     = r_req.sign;

    assign resp0_valid  = w_resp0_valid;
    assign resp1_valid  = w_resp1_valid;
    assign resp0_result = r_result;
    assign resp1_result = r_result;
    assign resp0_tag    = TAG_W'(r_req.tag);
    assign resp1_tag    = TAG_W'(r_req.tag);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_ctrl
// Description : Directed self-checking bench with a behavioural multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_ctrl;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic             req0_sign, req1_sign;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             req0_ready, req1_ready;
    logic             resp0_valid, resp1_valid;
    logic [63:0]      resp0_result, resp1_result;
    logic [TAG_W-1:0] resp0_tag, resp1_tag;
    logic             resp0_ready, resp1_ready;
    logic             flush;
    logic             mul_start;
    logic [31:0]      mul_a, mul_b;
    logic             mul_sign;
    logic             mul_ready;
    logic [63:0]      mul_result;

    logic             m_ready = 1'b0;
    logic [63:0]      m_result = 64'd0;
    logic             stray_ready;
    logic [63:0]      stray_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul_share_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sign(req0_sign), .req0_tag(req0_tag), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sign(req1_sign), .req1_tag(req1_tag), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_result(resp0_result),
        .resp0_tag(resp0_tag), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_result(resp1_result),
        .resp1_tag(resp1_tag), .resp1_ready(resp1_ready),
        .flush(flush),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_sign(mul_sign),
        .mul_ready(mul_ready), .mul_result(mul_result)
    );

    function automatic logic [63:0] mul_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Single-cycle multiplier: done pulse and product one cycle after start.
    always @(posedge clk) begin
        m_ready  <= mul_start;
        m_result <= mul_start ? mul_prod(mul_a, mul_b, mul_sign) : 64'd0;
    end
    assign mul_ready  = m_ready | stray_ready;
    assign mul_result = stray_ready ? stray_result : m_result;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {63'd0, act}, {63'd0, exp});
    endtask

    task automatic set_req(input logic slot, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic s, input logic [3:0] t);
        if (slot) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sign = s; req1_tag = t;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sign = s; req0_tag = t;
        end
    endtask

    // Returns at the negedge of the cycle after the accept, request withdrawn.
    task automatic accept_op(input logic slot, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [3:0] t, output logic ok);
        int n;
        @(negedge clk);
        set_req(slot, 1'b1, a, b, s, t);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            #1;
            if ((slot ? req1_ready : req0_ready) === 1'b1) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chkb("accept_ready", ok, 1'b1);
        @(negedge clk);
        set_req(slot, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    endtask

    typedef struct {
        logic        slot;
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [3:0]  tag;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    task automatic run_op(input vec_t v);
        logic ok;
        accept_op(v.slot, v.a, v.b, v.sign, v.tag, ok);
        if (!ok) return;
        chkb("start_n1", mul_start, 1'b1);
        chk("mul_a", {32'd0, mul_a}, {32'd0, v.a});
        chk("mul_b", {32'd0, mul_b}, {32'd0, v.b});
        chkb("mul_sign", mul_sign, v.sign);
        @(negedge clk);
        chkb("start_n2", mul_start, 1'b0);
        chkb("resp_early", v.slot ? resp1_valid : resp0_valid, 1'b0);
        @(negedge clk);
        chkb("resp_valid", v.slot ? resp1_valid : resp0_valid, 1'b1);
        chk("resp_result", v.slot ? resp1_result : resp0_result, v.exp);
        chk("resp_tag", {60'd0, v.slot ? resp1_tag : resp0_tag}, {60'd0, v.tag});
        chkb("other_resp", v.slot ? resp0_valid : resp1_valid, 1'b0);
        if (v.hold > 0) begin
            set_req(!v.slot, 1'b1, 32'd1, 32'd1, 1'b0, 4'd0);
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                chkb("hold_valid", v.slot ? resp1_valid : resp0_valid, 1'b1);
                chk("hold_result", v.slot ? resp1_result : resp0_result, v.exp);
                chk("hold_tag", {60'd0, v.slot ? resp1_tag : resp0_tag}, {60'd0, v.tag});
                chkb("hold_ready0", req0_ready, 1'b0);
                chkb("hold_ready1", req1_ready, 1'b0);
            end
        end
        if (v.slot) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        chkb("resp_done", v.slot ? resp1_valid : resp0_valid, 1'b0);
        if (v.hold > 0) begin
            #1;
            chkb("resume_ready", v.slot ? req0_ready : req1_ready, 1'b1);
            set_req(!v.slot, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        end
    endtask

    vec_t vecs[7];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic ok;
        int acc_slot[$];
        int acc_cyc[$];
        vec_t v;

        vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h3, 64'hFFFFFFFE00000001, 0};
        vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 1'b1, 4'h5, 64'hFFFFFFFFFFFFFFEB, 0};
        vecs[2] = '{1'b0, 32'h80000000, 32'h80000000, 1'b1, 4'hA, 64'h4000000000000000, 0};
        vecs[3] = '{1'b1, 32'h80000000, 32'h00000002, 1'b0, 4'h1, 64'h0000000100000000, 0};
        vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'hF, 64'h0000000000000001, 0};
        vecs[5] = '{1'b0, 32'h12345678, 32'h00000010, 1'b0, 4'h7, 64'h0000000123456780, 5};
        vecs[6] = '{1'b1, 32'h00000000, 32'hDEADBEEF, 1'b1, 4'h9, 64'h0000000000000000, 2};

        rst = 1'b1; flush = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
        stray_ready = 1'b0; stray_result = 64'd0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        chkb("rst_resp0_valid", resp0_valid, 1'b0);
        chkb("rst_resp1_valid", resp1_valid, 1'b0);
        chkb("rst_mul_start", mul_start, 1'b0);
        chk("rst_mul_a", {32'd0, mul_a}, 64'd0);
        chk("rst_result", resp0_result, 64'd0);
        rst = 1'b0;

        // Both slots contend from reset: grants must alternate starting at 0.
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        set_req(1'b0, 1'b1, 32'd3, 32'd4, 1'b0, 4'd1);
        set_req(1'b1, 1'b1, 32'd5, 32'd6, 1'b0, 4'd2);
        for (int cyc = 0; cyc < 40 && acc_slot.size() < 4; cyc++) begin
            #1;
            chkb("rr_dual_grant", req0_ready & req1_ready, 1'b0);
            if (req0_ready) begin acc_slot.push_back(0); acc_cyc.push_back(cyc); end
            else if (req1_ready) begin acc_slot.push_back(1); acc_cyc.push_back(cyc); end
            if (resp0_valid) chk("rr_res0", resp0_result, 64'd12);
            if (resp1_valid) chk("rr_res1", resp1_result, 64'd30);
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            if (resp0_valid) chk("rr_res0", resp0_result, 64'd12);
            if (resp1_valid) chk("rr_res1", resp1_result, 64'd30);
            @(negedge clk);
        end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        chk("rr_count", 64'(acc_slot.size()), 64'd4);
        for (int i = 0; i < acc_slot.size(); i++) begin
            chk("rr_order", 64'(acc_slot[i]), 64'(i % 2));
            if (i > 0) chk("rr_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);
        end

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Flush while waiting for the multiplier: result dropped.
        accept_op(1'b0, 32'd7, 32'd9, 1'b0, 4'h4, ok);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chkb("flw_resp0", resp0_valid, 1'b0);
        chkb("flw_resp1", resp1_valid, 1'b0);
        @(negedge clk);
        chkb("flw_resp0_late", resp0_valid, 1'b0);
        v = '{1'b0, 32'd2, 32'd5, 1'b0, 4'h6, 64'd10, 0};
        run_op(v);

        // Flush during issue: start still goes out, result dropped.
        accept_op(1'b1, 32'd11, 32'd13, 1'b0, 4'h8, ok);
        chkb("fli_start", mul_start, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chkb("fli_start_off", mul_start, 1'b0);
        @(negedge clk);
        chkb("fli_resp1", resp1_valid, 1'b0);
        @(negedge clk);
        chkb("fli_resp1_late", resp1_valid, 1'b0);
        v = '{1'b1, 32'd3, 32'd3, 1'b0, 4'h2, 64'd9, 0};
        run_op(v);

        // Flush while the response is pending, then flush in idle.
        accept_op(1'b0, 32'd6, 32'd7, 1'b0, 4'hB, ok);
        @(negedge clk);
        @(negedge clk);
        chkb("flr_valid", resp0_valid, 1'b1);
        chk("flr_result", resp0_result, 64'd42);
        flush = 1'b1;
        @(negedge clk);
        chkb("flr_dropped", resp0_valid, 1'b0);
        set_req(1'b0, 1'b1, 32'd1, 32'd1, 1'b0, 4'd0);
        #1;
        chkb("fl_idle_ready", req0_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        chkb("fl_idle_no_start", mul_start, 1'b0);

        // Reset mid-operation after a slot-0 accept leaves the pointer at 1.
        accept_op(1'b0, 32'h1111, 32'h2222, 1'b0, 4'hC, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chkb("rstw_resp0", resp0_valid, 1'b0);
        chkb("rstw_resp1", resp1_valid, 1'b0);
        chkb("rstw_start", mul_start, 1'b0);
        chk("rstw_mul_a", {32'd0, mul_a}, 64'd0);
        chk("rstw_mul_b", {32'd0, mul_b}, 64'd0);
        chkb("rstw_sign", mul_sign, 1'b0);
        chk("rstw_result", resp0_result, 64'd0);
        chk("rstw_tag", {60'd0, resp0_tag}, 64'd0);
        stray_ready = 1'b1;
        stray_result = 64'h1234;
        @(negedge clk);
        stray_ready = 1'b0;
        chkb("stray_resp0", resp0_valid, 1'b0);
        chkb("stray_resp1", resp1_valid, 1'b0);
        chk("stray_result", resp0_result, 64'd0);
        set_req(1'b0, 1'b1, 32'd4, 32'd4, 1'b0, 4'h1);
        set_req(1'b1, 1'b1, 32'd8, 32'd8, 1'b0, 4'h2);
        #1;
        chkb("rstw_win0", req0_ready, 1'b1);
        chkb("rstw_lose1", req1_ready, 1'b0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chkb("rstw_resp_valid", resp0_valid, 1'b1);
        chk("rstw_resp_result", resp0_result, 64'd16);
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
